// File: rtl/pipe_skid_stage.sv
// Parametrised pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// The input and output flags decode straight from the state register, so backpressure never ripples combinationally upstream.
module pipe_skid_stage #(
    parameter int                DATA_W = 96,
    parameter logic [DATA_W-1:0] BUBBLE = {64'h0, 32'h0000_0033}
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] head_nxt_s;
    logic [DATA_W-1:0] skid_r;
    logic [DATA_W-1:0] skid_nxt_s;
    logic              acc_s;
    logic              rel_s;

    // Handshake qualifiers; flush and stall suppress both sides.
    always_comb begin
        acc_s = in_valid & in_ready & ~stall & ~flush;
        rel_s = out_valid & out_ready & ~stall & ~flush;
    end

    // Next-state and storage update; flush dominates stall, stall dominates handshakes.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            head_nxt_s  = BUBBLE;
            skid_nxt_s  = BUBBLE;
        end else if (stall) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_nxt_s = ST_ONE;
                        head_nxt_s  = in_data;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && !rel_s) begin
                        state_nxt_s = ST_FULL;
                        skid_nxt_s  = in_data;
                    end else if (acc_s && rel_s) begin
                        head_nxt_s  = in_data;
                    end else if (rel_s) begin
                        state_nxt_s = ST_EMPTY;
                        head_nxt_s  = BUBBLE;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (rel_s) begin
                        state_nxt_s = ST_ONE;
                        head_nxt_s  = skid_r;
                        skid_nxt_s  = BUBBLE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    // Illegal encoding: recover to a clean empty stage.
                    state_nxt_s = ST_EMPTY;
                    head_nxt_s  = BUBBLE;
                    skid_nxt_s  = BUBBLE;
                end
            endcase
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_EMPTY;
            head_r  <= BUBBLE;
            skid_r  <= BUBBLE;
        end else begin
            state_r <= state_nxt_s;
            head_r  <= head_nxt_s;
            skid_r  <= skid_nxt_s;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        in_ready  = (state_r != ST_FULL);
        out_valid = (state_r != ST_EMPTY);
        if (out_valid) begin
            out_data = head_r;
        end else begin
            out_data = BUBBLE;
        end
        case (state_r)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_FULL:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage; each step compares {out_valid, in_ready, occupancy, out_data}.
module tb_pipe_skid_stage;

    localparam logic [95:0] BUB = {64'h0, 32'h0000_0033};

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic        stall;
    logic        flush;
    logic [1:0]  occupancy;

    logic [99:0] obs;
    logic [99:0] exp_v;
    int          n_checks;
    int          n_fails;

    pipe_skid_stage #(.DATA_W(96), .BUBBLE(BUB)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .flush(flush), .occupancy(occupancy)
    );

    assign obs = {out_valid, in_ready, occupancy, out_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [95:0] d, input logic ordy, input logic st, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        drive(1'b0, 96'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        exp_v = {1'b0, 1'b1, 2'd0, BUB};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL reset got %h want %h", obs, exp_v); end
        rstn = 1'b1;
        tick();
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL reset_idle got %h want %h", obs, exp_v); end
    endtask

    task automatic test_stream;
        drive(1'b1, 96'hA1, 1'b1, 1'b0, 1'b0);
        tick();
        exp_v = {1'b1, 1'b1, 2'd1, 96'hA1};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL stream_a1 got %h want %h", obs, exp_v); end
        in_data = 96'hA2;
        tick();
        exp_v = {1'b1, 1'b1, 2'd1, 96'hA2};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL stream_a2 got %h want %h", obs, exp_v); end
        in_data = 96'hA3;
        tick();
        exp_v = {1'b1, 1'b1, 2'd1, 96'hA3};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL stream_a3 got %h want %h", obs, exp_v); end
        in_valid = 1'b0;
        tick();
        exp_v = {1'b0, 1'b1, 2'd0, BUB};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL stream_drain got %h want %h", obs, exp_v); end
    endtask

    task automatic test_backpressure;
        drive(1'b1, 96'hB1, 1'b0, 1'b0, 1'b0);
        tick();
        exp_v = {1'b1, 1'b1, 2'd1, 96'hB1};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL bp_b1 got %h want %h", obs, exp_v); end
        in_data = 96'hB2;
        tick();
        exp_v = {1'b1, 1'b0, 2'd2, 96'hB1};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL bp_full got %h want %h", obs, exp_v); end
        // Held while not ready: a different payload must not enter.
        in_data = 96'hB9;
        tick();
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL bp_hold got %h want %h", obs, exp_v); end
        drive(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_v = {1'b1, 1'b1, 2'd1, 96'hB2};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL bp_release1 got %h want %h", obs, exp_v); end
        tick();
        exp_v = {1'b0, 1'b1, 2'd0, BUB};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL bp_release2 got %h want %h", obs, exp_v); end
    endtask

    task automatic test_flush_full;
        drive(1'b1, 96'hC1, 1'b0, 1'b0, 1'b0);
        tick();
        in_data = 96'hC2;
        tick();
        exp_v = {1'b1, 1'b0, 2'd2, 96'hC1};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL flush_fill got %h want %h", obs, exp_v); end
        drive(1'b1, 96'hC3, 1'b1, 1'b0, 1'b1);
        tick();
        exp_v = {1'b0, 1'b1, 2'd0, BUB};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL flush_full got %h want %h", obs, exp_v); end
        drive(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL flush_no_c3 got %h want %h", obs, exp_v); end
    endtask

    task automatic test_stall;
        drive(1'b1, 96'hD1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 96'hD2, 1'b1, 1'b1, 1'b0);
        exp_v = {1'b1, 1'b1, 2'd1, 96'hD1};
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_v) begin n_fails++; $display("FAIL stall_cyc%0d got %h want %h", i, obs, exp_v); end
        end
        stall = 1'b0;
        tick();
        exp_v = {1'b1, 1'b1, 2'd1, 96'hD2};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL stall_resume got %h want %h", obs, exp_v); end
        in_valid = 1'b0;
        tick();
        exp_v = {1'b0, 1'b1, 2'd0, BUB};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL stall_drain got %h want %h", obs, exp_v); end
    endtask

    task automatic test_flush_stall;
        drive(1'b1, 96'hE1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 96'hE2, 1'b1, 1'b1, 1'b1);
        tick();
        exp_v = {1'b0, 1'b1, 2'd0, BUB};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL flush_over_stall got %h want %h", obs, exp_v); end
        drive(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL flush_drop_e2 got %h want %h", obs, exp_v); end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 96'hF1, 1'b0, 1'b0, 1'b0);
        tick();
        in_data = 96'hF2;
        tick();
        exp_v = {1'b1, 1'b0, 2'd2, 96'hF1};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL arst_fill got %h want %h", obs, exp_v); end
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        exp_v = {1'b0, 1'b1, 2'd0, BUB};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL arst_immediate got %h want %h", obs, exp_v); end
        tick();
        rstn = 1'b1;
        drive(1'b1, 96'h61, 1'b1, 1'b0, 1'b0);
        tick();
        exp_v = {1'b1, 1'b1, 2'd1, 96'h61};
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL arst_recover got %h want %h", obs, exp_v); end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_stall();
        test_flush_stall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline-stage register; successor to the fixed-width IF/ID latch.
- Carries an arbitrary payload (e.g. {pc, npc, instr}) between two pipeline stages using a valid/ready handshake and a 2-entry skid buffer, so a registered `in_ready` never drops a beat.
- Keeps the stage-level `stall` and `flush` controls. Substitutes a configurable bubble (NOP) payload whenever the stage holds no valid data.
- Used between IF/ID, ID/EX, etc., wherever backpressure must be decoupled from the combinational path.

Parameters:
- DATA_W, 96, payload width in bits.
- BUBBLE, {64'h0, 32'h0000_0033}, payload driven on `out_data` when `out_valid`=0 (NOP: add x0,x0,x0 in the low word).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; registered, depends only on state.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  DATA_W  head payload, or BUBBLE when `out_valid`=0.
- stall  input  1  freeze: no accept, no release, state held.
- flush  input  1  discard all held entries.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Reset (`rstn`=0, async):
  - state=EMPTY; both entry valids=0.
  - `out_valid`=0, `out_data`=BUBBLE, `in_ready`=1, `occupancy`=0.
  - Both storage registers are loaded with BUBBLE.
- Storage: head register H (drives `out_data`) and skid register S.
- States: EMPTY (none), ONE (H valid), FULL (H and S valid).
- Derived signals:
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
  - `occupancy` = 0/1/2 for EMPTY/ONE/FULL.
  - `out_data` = H when `out_valid`, else BUBBLE.
- Handshake qualifiers:
  - acc = in_valid & in_ready & !stall & !flush.
  - rel = out_valid & out_ready & !stall & !flush.
- Priority: reset > flush > stall > normal.
- flush=1 (sampled at clk edge):
  - Next state EMPTY; H and S loaded with BUBBLE.
  - Any input presented that cycle is dropped.
  - Flush wins over stall and over a simultaneous handshake.
- stall=1, flush=0: all registers and state unchanged, whatever `in_valid` and `out_ready` are.
- Normal transitions:
  - EMPTY, acc → ONE; H<=in_data.
  - ONE, acc & !rel → FULL; S<=in_data.
  - ONE, acc & rel → ONE; H<=in_data (zero-bubble throughput, 1 beat/cycle).
  - ONE, !acc & rel → EMPTY; H<=BUBBLE.
  - FULL, rel → ONE; H<=S, S<=BUBBLE. No accept is possible because `in_ready`=0.
  - Any other combination → hold.
- Latency and ordering:
  - Input accepted at edge N appears on `out_data` after edge N when the stage was empty.
  - Order is strictly FIFO; no beat is lost or duplicated.
- `in_valid` with `in_ready`=0: no effect; upstream must hold its payload (standard valid/ready rules).
- `in_ready` and `out_valid` are pure functions of state. There is no combinational path from `out_ready` to `in_ready`.
- Reset asserted mid-transfer: immediate return to reset values; held payloads are lost.

Test Plan:
- Reset then stream 0xA1, 0xA2, 0xA3 (low word) with `out_ready`=1 → appear on `out_data` one cycle after each accept, back-to-back; `occupancy` stays 1; `in_ready` stays 1.
- Backpressure:
  - Stimulus: `out_ready`=0 while sending 0xB1, then 0xB2.
  - Required: `occupancy` 1 then 2; `in_ready` drops to 0 after the second accept; `out_data` holds 0xB1.
  - Then raise `out_ready`: 0xB1 and 0xB2 drain in order; `in_ready` returns to 1 after the first release.
- FULL state plus flush=1 with `in_valid`=1 (payload 0xC3) → next cycle:
  - `occupancy`=0, `out_valid`=0.
  - `out_data`=BUBBLE (low word 0x0000_0033).
  - 0xC3 is never output.
- stall=1 for 3 cycles in ONE with `in_valid`=1 and `out_ready`=1 → state, `out_data` and `occupancy` frozen; no accept. On release, normal flow resumes with no loss or duplicate.
- flush and stall asserted in the same cycle → flush wins; stage is EMPTY next cycle.
- Assert `rstn`=0 asynchronously between edges while FULL → outputs go to reset values immediately, without waiting for a clock edge.
